// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared width defaults for the FIR carry-save final adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int FIR_OP_WIDTH   = 64;
    localparam int FIR_OUT_WIDTH  = 32;
    localparam int FIR_HALF_WIDTH = FIR_OP_WIDTH / 2;

    // Largest / smallest representable signed value of a given width.
    function automatic logic [FIR_OP_WIDTH-1:0] fir_sat_max(input int width);
        logic [FIR_OP_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < width - 1; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [FIR_OP_WIDTH-1:0] fir_sat_min(input int width);
        logic [FIR_OP_WIDTH-1:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sat_trunc.sv
// ============================================================================
// Module      : fir_sat_trunc
// Description : Arithmetic right shift followed by signed saturation (comb).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sat_trunc
    import fir_pkg::*;
#(
    parameter int OP_WIDTH  = FIR_OP_WIDTH,
    parameter int OUT_WIDTH = FIR_OUT_WIDTH,
    parameter int SHIFT     = 0
) (
    input  logic [OP_WIDTH-1:0]  sum_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 sat_o
);

    localparam int TOP_WIDTH = OP_WIDTH - OUT_WIDTH + 1;

    localparam logic [FIR_OP_WIDTH-1:0] C_MAX_FULL = fir_sat_max(OUT_WIDTH);
    localparam logic [FIR_OP_WIDTH-1:0] C_MIN_FULL = fir_sat_min(OUT_WIDTH);
    localparam logic [OUT_WIDTH-1:0]    C_MAX      = C_MAX_FULL[OUT_WIDTH-1:0];
    localparam logic [OUT_WIDTH-1:0]    C_MIN      = C_MIN_FULL[OUT_WIDTH-1:0];

    logic signed [OP_WIDTH-1:0] w_shifted;
    logic [TOP_WIDTH-1:0]       w_top;
    logic                       w_sat;

    assign w_shifted = $signed(sum_i) >>> SHIFT;

    // In range exactly when every bit from the output sign bit upward agrees.
    assign w_top = w_shifted[OP_WIDTH-1 -: TOP_WIDTH];
    assign w_sat = ~((&w_top) | ~(|w_top));

    always_comb begin
        data_o = w_shifted[OUT_WIDTH-1:0];
        sat_o  = w_sat;
        if (w_sat) begin
            data_o = w_shifted[OP_WIDTH-1] ? C_MIN : C_MAX;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_csa_final_adder.sv
// ============================================================================
// Module      : fir_csa_final_adder
// Description : 3-stage split carry-propagate adder, shift and saturate,
//               with per-stage valid bits and ready/valid backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_csa_final_adder
    import fir_pkg::*;
#(
    parameter int OP_WIDTH  = FIR_OP_WIDTH,
    parameter int OUT_WIDTH = FIR_OUT_WIDTH,
    parameter int SHIFT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  in_op0,
    input  logic [OP_WIDTH-1:0]  in_op1,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 out_sat
);

    localparam int HALF_WIDTH = OP_WIDTH / 2;
    localparam int HI_WIDTH   = OP_WIDTH - HALF_WIDTH;

    // Stage 1: low-half sum and carry, high halves passed through.
    logic                  s1_valid_q, s1_valid_d;
    logic [HALF_WIDTH-1:0] s1_lo_q,    s1_lo_d;
    logic                  s1_c_q,     s1_c_d;
    logic [HI_WIDTH-1:0]   s1_hi0_q,   s1_hi0_d;
    logic [HI_WIDTH-1:0]   s1_hi1_q,   s1_hi1_d;
    logic                  s1_last_q,  s1_last_d;

    // Stage 2: full-width sum.
    logic                  s2_valid_q, s2_valid_d;
    logic [OP_WIDTH-1:0]   s2_sum_q,   s2_sum_d;
    logic                  s2_last_q,  s2_last_d;

    // Stage 3: saturated result.
    logic                  s3_valid_q, s3_valid_d;
    logic [OUT_WIDTH-1:0]  s3_data_q,  s3_data_d;
    logic                  s3_sat_q,   s3_sat_d;
    logic                  s3_last_q,  s3_last_d;

    logic                  w_s3_free;
    logic                  w_s2_adv;
    logic                  w_s2_free;
    logic                  w_s1_adv;
    logic                  w_s1_free;
    logic                  w_accept;
    logic [HALF_WIDTH:0]   w_lo_sum;
    logic [HI_WIDTH-1:0]   w_hi_sum;
    logic [OUT_WIDTH-1:0]  w_sat_data;
    logic                  w_sat_flag;

    // A stage may take new data when it is empty or its content moves on.
    assign w_s3_free = ~s3_valid_q | out_ready;
    assign w_s2_adv  = s2_valid_q & w_s3_free;
    assign w_s2_free = ~s2_valid_q | w_s2_adv;
    assign w_s1_adv  = s1_valid_q & w_s2_free;
    assign w_s1_free = ~s1_valid_q | w_s1_adv;

    assign in_ready  = w_s1_free & ~rst;
    assign w_accept  = in_valid & in_ready;

    assign w_lo_sum  = {1'b0, in_op0[HALF_WIDTH-1:0]} + {1'b0, in_op1[HALF_WIDTH-1:0]};
    assign w_hi_sum  = s1_hi0_q + s1_hi1_q + {{(HI_WIDTH-1){1'b0}}, s1_c_q};

    fir_sat_trunc #(
        .OP_WIDTH  (OP_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_sat_trunc (
        .sum_i  (s2_sum_q),
        .data_o (w_sat_data),
        .sat_o  (w_sat_flag)
    );

    always_comb begin
        s1_valid_d = w_s1_free ? w_accept : s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_c_d     = s1_c_q;
        s1_hi0_d   = s1_hi0_q;
        s1_hi1_d   = s1_hi1_q;
        s1_last_d  = s1_last_q;
        if (w_accept) begin
            s1_lo_d   = w_lo_sum[HALF_WIDTH-1:0];
            s1_c_d    = w_lo_sum[HALF_WIDTH];
            s1_hi0_d  = in_op0[OP_WIDTH-1:HALF_WIDTH];
            s1_hi1_d  = in_op1[OP_WIDTH-1:HALF_WIDTH];
            s1_last_d = in_last;
        end
    end

    always_comb begin
        s2_valid_d = w_s2_free ? w_s1_adv : s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_last_d  = s2_last_q;
        if (w_s1_adv) begin
            s2_sum_d  = {w_hi_sum, s1_lo_q};
            s2_last_d = s1_last_q;
        end
    end

    always_comb begin
        s3_valid_d = w_s3_free ? w_s2_adv : s3_valid_q;
        s3_data_d  = s3_data_q;
        s3_sat_d   = s3_sat_q;
        s3_last_d  = s3_last_q;
        if (w_s2_adv) begin
            s3_data_d = w_sat_data;
            s3_sat_d  = w_sat_flag;
            s3_last_d = s2_last_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_c_q     <= 1'b0;
            s1_hi0_q   <= '0;
            s1_hi1_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_last_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_sat_q   <= 1'b0;
            s3_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lo_q    <= s1_lo_d;
            s1_c_q     <= s1_c_d;
            s1_hi0_q   <= s1_hi0_d;
            s1_hi1_q   <= s1_hi1_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_last_q  <= s2_last_d;
            s3_valid_q <= s3_valid_d;
            s3_data_q  <= s3_data_d;
            s3_sat_q   <= s3_sat_d;
            s3_last_q  <= s3_last_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_data  = s3_data_q;
    assign out_sat   = s3_sat_q;
    assign out_last  = s3_last_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_csa_final_adder.sv
// ============================================================================
// Module      : tb_fir_csa_final_adder
// Description : Directed self-checking bench; a SHIFT=8 copy shares stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_csa_final_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_op0;
    logic [63:0] in_op1;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_sat;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic        out_last2;
    logic        out_sat2;

    int n_vec  = 0;
    int n_fail = 0;

    logic [63:0] v_op0 [8];
    logic [63:0] v_op1 [8];
    logic        v_last[8];
    logic [31:0] e_data[8];
    logic        e_sat [8];
    logic        e_last[8];
    logic [31:0] e2_data[8];
    logic        e2_sat [8];
    bit          chk2;

    fir_csa_final_adder #(.OP_WIDTH(64), .OUT_WIDTH(32), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op0(in_op0), .in_op1(in_op1), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sat(out_sat)
    );

    fir_csa_final_adder #(.OP_WIDTH(64), .OUT_WIDTH(32), .SHIFT(8)) dut_sh8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op0(in_op0), .in_op1(in_op1), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_last(out_last2), .out_sat(out_sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic l, input logic [31:0] d, input logic s);
        v_op0[i]  = a;
        v_op1[i]  = b;
        v_last[i] = l;
        e_data[i] = d;
        e_sat[i]  = s;
        e_last[i] = l;
    endtask

    // Streams n vectors; out_ready is held low for the first 'hold' cycles.
    task automatic run(input string tag, input int n, input int hold, input int exp_cyc);
        int  sent;
        int  rcvd;
        int  cyc;
        bit  acc;
        bit  drn;
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < n && cyc < 200) begin
            if (hold > 0 && cyc == hold) begin
                chk({tag, "_accepts_before_full"}, 64'(sent), 64'd3);
                chk({tag, "_in_ready_full"}, 64'(in_ready), 64'd0);
                chk({tag, "_held_data"}, 64'(out_data), 64'(e_data[0]));
            end
            out_ready = (cyc >= hold);
            if (sent < n) begin
                in_valid = 1'b1;
                in_op0   = v_op0[sent];
                in_op1   = v_op1[sent];
                in_last  = v_last[sent];
            end else begin
                in_valid = 1'b0;
                in_op0   = '0;
                in_op1   = '0;
                in_last  = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                chk($sformatf("%s_data%0d", tag, rcvd), 64'(out_data), 64'(e_data[rcvd]));
                chk($sformatf("%s_sat%0d", tag, rcvd), 64'(out_sat), 64'(e_sat[rcvd]));
                chk($sformatf("%s_last%0d", tag, rcvd), 64'(out_last), 64'(e_last[rcvd]));
                if (chk2) begin
                    chk($sformatf("%s_sh8_data%0d", tag, rcvd), 64'(out_data2), 64'(e2_data[rcvd]));
                    chk($sformatf("%s_sh8_sat%0d", tag, rcvd), 64'(out_sat2), 64'(e2_sat[rcvd]));
                end
                rcvd++;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        chk({tag, "_beats_received"}, 64'(rcvd), 64'(n));
        if (exp_cyc > 0) chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int n_seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op0    = '0;
        in_op1    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        chk2      = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_in_ready_sh8", 64'(in_ready2), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 5 + 7 with latency check
        in_valid = 1'b1;
        in_op0   = 64'd5;
        in_op1   = 64'd7;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_edge1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge3_valid", 64'(out_valid), 64'd1);
        chk("add_5_7_data", 64'(out_data), 64'd12);
        chk("add_5_7_sat", 64'(out_sat), 64'd0);
        chk("add_5_7_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #1;
        chk("drained_valid", 64'(out_valid), 64'd0);

        // Carry across halves, sign handling and clip boundaries, back to back
        set_vec(0, 64'h00000000_FFFFFFFF, 64'h1,                  1'b0, 32'h7FFFFFFF, 1'b1);
        set_vec(1, 64'hFFFFFFFF_FFFFFFFD, 64'h1,                  1'b0, 32'hFFFFFFFE, 1'b0);
        set_vec(2, 64'hFFFFFFFE_00000000, 64'h0,                  1'b0, 32'h80000000, 1'b1);
        set_vec(3, 64'h7FFFFFFF_FFFFFFFF, 64'h1,                  1'b0, 32'h80000000, 1'b1);
        set_vec(4, 64'h00000000_7FFFFFFF, 64'h0,                  1'b0, 32'h7FFFFFFF, 1'b0);
        set_vec(5, 64'h00000000_80000000, 64'hFFFFFFFF_80000000,  1'b0, 32'h00000000, 1'b0);
        set_vec(6, 64'hFFFFFFFF_80000000, 64'h0,                  1'b1, 32'h80000000, 1'b0);
        run("stream", 7, 0, 10);

        // Backpressure: 5 beats offered, consumer stalled for 10 cycles
        for (int k = 0; k < 5; k++) begin
            set_vec(k, 64'(100 * (k + 1)), 64'(k + 1), (k == 4), 32'(101 * (k + 1)), 1'b0);
        end
        run("stall", 5, 10, 0);

        // Arithmetic shift by 8 on the second instance
        chk2 = 1'b1;
        set_vec(0, 64'h00000000_00012345, 64'h0,  1'b0, 32'h00012345, 1'b0);
        set_vec(1, 64'h00000080_00000000, 64'h0,  1'b0, 32'h7FFFFFFF, 1'b1);
        set_vec(2, 64'hFFFFFFFF_FFFFFF00, 64'h0,  1'b0, 32'hFFFFFF00, 1'b0);
        set_vec(3, 64'hFFFFFFFF_FFFFFE00, 64'h80, 1'b0, 32'hFFFFFE80, 1'b0);
        set_vec(4, 64'h0000007F_FFFFFF00, 64'hFF, 1'b1, 32'h7FFFFFFF, 1'b1);
        e2_data[0] = 32'h00000123; e2_sat[0] = 1'b0;
        e2_data[1] = 32'h7FFFFFFF; e2_sat[1] = 1'b1;
        e2_data[2] = 32'hFFFFFFFF; e2_sat[2] = 1'b0;
        e2_data[3] = 32'hFFFFFFFE; e2_sat[3] = 1'b0;
        e2_data[4] = 32'h7FFFFFFF; e2_sat[4] = 1'b0;
        run("shift8", 5, 0, 8);
        chk2 = 1'b0;

        // Reset with two samples in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op0    = 64'd1;
        in_op1    = 64'd2;
        @(posedge clk);
        #1;
        in_op0 = 64'd3;
        in_op1 = 64'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        chk("inflight_data", 64'(out_data), 64'd3);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
        n_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) n_seen++;
            @(posedge clk);
            #1;
        end
        chk("no_output_after_rst", 64'(n_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_csa_final_adder.md
FIR_CSA_FINAL_ADDER -- requirements
Module: fir_csa_final_adder

Interface
REQ-001 The block SHALL have parameter OP_WIDTH, default 64, giving the width of each carry-save input operand.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 32, giving the width of the signed saturated result.
REQ-003 The block SHALL have parameter SHIFT, default 0, giving the arithmetic right-shift applied before saturation (0..OP_WIDTH-OUT_WIDTH).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  sole clock, all state on rising edge.
REQ-006 Port: rst  input  1  asynchronous active-high reset.
REQ-007 Port: in_valid  input  1  operand pair valid.
REQ-008 Port: in_ready  output  1  block accepts the pair this cycle.
REQ-009 Port: in_op0  input  OP_WIDTH  carry-save operand 0 (output 0 of the 19-to-2 reduction tree).
REQ-010 Port: in_op1  input  OP_WIDTH  carry-save operand 1 (output 1 of the tree).
REQ-011 Port: in_last  input  1  last sample of frame, carried alongside data.
REQ-012 Port: out_valid  output  1  result valid.
REQ-013 Port: out_ready  input  1  consumer accepts result.
REQ-014 Port: out_data  output  OUT_WIDTH  signed saturated result.
REQ-015 Port: out_last  output  1  in_last of the same sample.
REQ-016 Port: out_sat  output  1  result was clipped.

Function
REQ-017 Transfer SHALL occur on a rising edge where valid and ready are both 1 (input and output side independently).
REQ-018 Stage 1 SHALL add the low OP_WIDTH/2 bits of both operands, registering low sum, carry-out bit, both high halves, and last.
REQ-019 Stage 2 SHALL add both high halves plus the stage-1 carry, registering the full OP_WIDTH sum (modulo 2^OP_WIDTH, two's complement) and last.
REQ-020 Stage 3 SHALL arithmetic-right-shift the sum by SHIFT, clip to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and register out_data, out_sat, out_last.
REQ-021 out_sat SHALL be 1 exactly when the shifted value lies outside that range; clipping values are 0x7FFFFFFF / 0x80000000 at default width.
REQ-022 Latency SHALL be 3 cycles from input handshake to out_valid with out_ready held 1; throughput 1 sample/cycle.
REQ-023 Each stage SHALL hold its own valid bit and advance when the next stage is empty or advancing (bubble-collapsing); no sample lost or duplicated.
REQ-024 in_ready SHALL equal (stage-1 empty) OR (stage 1 advancing), and SHALL be 0 while rst=1.
REQ-025 With out_ready=0, out_data/out_sat/out_last SHALL stay stable while out_valid=1; at most 3 samples are held in flight.
REQ-026 Simultaneous input accept and output drain in one cycle SHALL both occur; sample order SHALL be preserved.

Reset
REQ-027 On rst assertion all stage valid bits, out_valid, out_data, out_sat, out_last SHALL go 0 immediately, discarding in-flight samples.
REQ-028 After rst deasserts, in_ready SHALL be 1 on the first clock edge with the pipeline empty.

Structure
REQ-029 OP_WIDTH, OUT_WIDTH and HALF_WIDTH (OP_WIDTH/2) defaults SHALL live in shared package fir_pkg.
REQ-030 Shift-and-saturate logic SHALL be combinational sub-module fir_sat_trunc (inputs sum, outputs data and sat flag).

Verification
REQ-031 op0=5, op1=7, out_ready=1 -> out_data=12, out_sat=0, out_valid 3 cycles after handshake.
REQ-032 op0=0x00000000_FFFFFFFF, op1=1 (cross-half carry) -> sum 0x1_00000000 -> out_data=0x7FFFFFFF, out_sat=1.
REQ-033 op0=0xFFFFFFFF_FFFFFFFD, op1=1 -> out_data=0xFFFFFFFE (-2), out_sat=0; op0=-2^33, op1=0 -> 0x80000000, out_sat=1.
REQ-034 out_ready=0 for 10 cycles, 5 beats offered (beat 5 in_last=1) -> in_ready drops after 3 accepts; release yields beats 1..5 in order, out_last only on beat 5.
REQ-035 rst asserted with 2 samples in flight -> out_valid=0 same cycle; nothing emitted after deassert; in_ready=1 next edge.
REQ-036 SHIFT=8, sum 0x12345 -> out_data=0x123, out_sat=0.
